// File: rtl/fp_mul_result_stage.sv
// fp_mul_result_stage: corrects the raw FP multiplier word and buffers it in a 2-entry skid FIFO
module fp_mul_result_stage #(
  parameter logic [31:0] QNAN  = 32'h7FC0_0000,
  parameter int          DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic [2:0]  sticky_flags,
  input  logic        flag_clr
);
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        s, norm, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, invalid;
  logic [9:0]  e_true;
  logic [31:0] res_c;
  logic [2:0]  flags_c;
  logic        push, pop, wr_q, rd_q, wr_d, rd_d;
  logic [1:0]  count_q, count_d;
  logic [2:0]  sticky_q, sticky_d;
  logic [34:0] mem_q [2];
  logic        prod_sign_unused;
  assign {ea, ma} = in_a[30:0];
  assign {eb, mb} = in_b[30:0];
  assign s = in_a[31] ^ in_b[31];
  assign prod_sign_unused = in_prod[31];
  assign a_nan  = (&ea) && (ma != '0);
  assign b_nan  = (&eb) && (mb != '0);
  assign a_inf  = (&ea) && (ma == '0);
  assign b_inf  = (&eb) && (mb == '0);
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign invalid = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  // norm is the LSB of (prod_exp - (ea+eb-127)) mod 256; the full difference is only ever 0 or 1
  assign norm = in_prod[23] ^ ea[0] ^ eb[0] ^ 1'b1;
  // two's-complement 10-bit true exponent; bit 9 set means negative
  assign e_true = {2'b0, ea} + {2'b0, eb} + {9'b0, norm} - 10'd127;
  // special-case and exponent-range correction ahead of the FIFO write
  always_comb begin
    res_c   = {s, e_true[7:0], in_prod[22:0]};
    flags_c = 3'b000;
    if (invalid) begin
      res_c   = QNAN;
      flags_c = 3'b100;
    end else if (a_inf || b_inf) begin
      res_c = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      res_c = {s, 31'd0};
    end else if (!e_true[9] && e_true >= 10'd255) begin
      res_c   = {s, 8'hFF, 23'd0};
      flags_c = 3'b010;
    end else if (e_true[9] || e_true == '0) begin
      res_c   = {s, 31'd0};
      flags_c = 3'b001;
    end
  end
  assign in_ready  = count_q != 2'(DEPTH);
  assign out_valid = count_q != '0;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign {out_flags, out_result} = out_valid ? mem_q[rd_q] : 35'd0;
  assign sticky_flags = sticky_q;
  // FIFO pointer/count and sticky flag next-state; a clear with a push keeps only the pushed flags
  always_comb begin
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    wr_d     = wr_q ^ push;
    rd_d     = rd_q ^ pop;
    sticky_d = flag_clr ? (push ? flags_c : 3'b000) : (sticky_q | (push ? flags_c : 3'b000));
  end
  // state registers; reset discards all buffered entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      sticky_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      sticky_q <= sticky_d;
      if (push) mem_q[wr_q] <= {flags_c, res_c};
    end
  end
endmodule

// File: tb/tb_fp_mul_result_stage.sv
// tb_fp_mul_result_stage: directed vectors with hand-computed results for fp_mul_result_stage
module tb_fp_mul_result_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, flag_clr = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] in_a = '0, in_b = '0, in_prod = '0, out_result;
  logic [2:0]  out_flags, sticky_flags;
  int          checks = 0, errors = 0;
  logic [31:0] got [8];
  int          n_got;
  logic        pushed;

  fp_mul_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    in_a = a; in_b = b; in_prod = p; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] p, input logic [31:0] r, input logic [2:0] f);
    send(a, b, p);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, out_result, r);
    check({tag, "_flags"}, 32'(out_flags), 32'(f));
  endtask

  initial begin
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    #4 rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send_check("mul2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40C0_0000, 3'b000);
    send_check("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b010);
    check("ovf_sticky", 32'(sticky_flags), 32'b010);
    send_check("unf", 32'h9F80_0000, 32'h1F80_0000, 32'hFF80_0000, 32'h8000_0000, 3'b001);
    check("unf_sticky", 32'(sticky_flags), 32'b011);
    send_check("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100);
    send_check("nan_op", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 3'b100);
    send_check("denorm", 32'h0000_0001, 32'hBF80_0000, 32'h8000_0000, 32'h8000_0000, 3'b000);
    send_check("inf_x_fin", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 32'hFF80_0000, 3'b000);
    check("all_sticky", 32'(sticky_flags), 32'b111);
    tick();
    check("drained", 32'(out_valid), 32'd0);

    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("clr_no_push", 32'(sticky_flags), 32'd0);

    out_ready = 1'b0;
    in_a = 32'h3F80_0000; in_b = 32'h3F80_0000; in_valid = 1'b1;
    in_prod = 32'h3F80_0001;
    tick();
    check("bp_ready1", 32'(in_ready), 32'd1);
    in_prod = 32'h3F80_0002;
    tick();
    check("bp_ready2", 32'(in_ready), 32'd0);
    check("bp_head", out_result, 32'h3F80_0001);
    in_prod = 32'h3F80_0003;
    tick();
    check("bp_blocked", 32'(in_ready), 32'd0);
    check("bp_hold", out_result, 32'h3F80_0001);
    out_ready = 1'b1;
    n_got = 0;
    pushed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && n_got < 8) begin
        got[n_got] = out_result;
        n_got++;
      end
      if (in_valid && in_ready) pushed = 1'b1;
      tick();
      if (pushed) in_valid = 1'b0;
    end
    check("bp_count", 32'(n_got), 32'd3);
    check("bp_p0", got[0], 32'h3F80_0001);
    check("bp_p1", got[1], 32'h3F80_0002);
    check("bp_p2", got[2], 32'h3F80_0003);

    out_ready = 1'b0;
    send(32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000);
    send(32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_sticky", 32'(sticky_flags), 32'b010);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", out_result, 32'd0);
    check("midrst_sticky", 32'(sticky_flags), 32'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    send(32'h9F80_0000, 32'h1F80_0000, 32'hFF80_0000);
    check("pre_clr_sticky", 32'(sticky_flags), 32'b001);
    flag_clr = 1'b1;
    send(32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000);
    flag_clr = 1'b0;
    check("clr_with_push", 32'(sticky_flags), 32'b010);
    check("clr_push_flags", 32'(out_flags), 32'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mul_result_stage.md
Name: fp_mul_result_stage

Overview:
- Registered output stage directly downstream of the combinational single-precision FP multiplier.
- Takes the raw multiplier word plus the original operands, and fixes the exponent wrap and special cases that the multiplier does not handle (overflow, underflow, NaN, Inf, zero, denormal).
- Buffers results in a 2-entry skid FIFO with a valid/ready handshake toward the next pipeline stage.
- Maintains sticky exception flags.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet NaN emitted for every NaN/invalid result.
- DEPTH, 2, result buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_a/in_b/in_prod valid
- in_ready  output  1  stage can accept
- in_a  input  32  operand A as presented to multiplier
- in_b  input  32  operand B as presented to multiplier
- in_prod  input  32  multiplier output for in_a*in_b
- out_valid  output  1  out_result/out_flags valid
- out_ready  input  1  downstream accepts
- out_result  output  32  corrected IEEE-754 single result
- out_flags  output  3  {invalid, overflow, underflow} for out_result
- sticky_flags  output  3  OR of flags of all results accepted since reset/clear
- flag_clr  input  1  synchronous clear of sticky_flags

Behaviour:
- Reset (async, rst_n=0):
  - FIFO count=0, out_valid=0, out_result=0, out_flags=0, sticky_flags=0.
  - in_ready=1 once rst_n=1.
  - Reset mid-transfer discards all buffered entries.
- Handshake:
  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
  - in_ready = (count<2), from registered count only; no combinational path from out_ready.
  - out_valid = (count!=0). out_result/out_flags show the head entry and hold stable while out_valid&&!out_ready.
- Latency: a word pushed at edge k is visible with out_valid=1 after edge k (1 cycle) if the FIFO was empty.
- Ordering: strict FIFO. Simultaneous push and pop at count=1 leaves count=1. Push is blocked when count=2.
- Correction logic (combinational, before the FIFO write); ea=in_a[30:23], eb=in_b[30:23], ma/mb=mantissas, s=in_a[31]^in_b[31]:
  - NaN operand (e=255, m!=0), or Inf*zero: result=QNAN, invalid=1.
  - Inf operand, other operand nonzero/finite: result={s,8'hFF,23'd0}, overflow=0.
  - Zero or denormal operand (e=0, denormals treated as zero): result={s,31'd0}, no flags.
  - Otherwise:
    - Normalisation bit n=(in_prod[30:23]-(ea+eb-127)) mod 256. The value is 0 or 1 by construction.
    - True exponent E=ea+eb-127+n, computed as 10-bit signed.
    - E>=255: result={s,8'hFF,23'd0}, overflow=1.
    - E<=0: result={s,31'd0}, underflow=1 (flush to zero).
    - Else: result={s,E[7:0],in_prod[22:0]}.
- Sticky flags:
  - sticky_flags |= flags of each pushed entry.
  - If flag_clr coincides with a push, the push's flags survive: new value = pushed flags only.
- No rounding is performed; the mantissa passes through unchanged from in_prod.

Test Plan:
1. A=0x40000000, B=0x40400000, prod=0x40C00000, out_ready=1 → one cycle later out_valid=1, out_result=0x40C00000, out_flags=000.
2. A=B=0x7F000000, prod=0x3E800000 → out_result=0x7F800000, out_flags=010, sticky_flags=010.
3. A=0x9F800000, B=0x1F800000, prod=0xFF800000 → out_result=0x80000000, out_flags=001.
4. Special cases:
   - A=0x7F800000, B=0x00000000 → 0x7FC00000, flags=100.
   - A=0x7FC00001, B=0x3F800000 → 0x7FC00000, flags=100.
   - A=0x00000001 (denormal), B=0xBF800000 → 0x80000000, flags=000.
5. Backpressure:
   - out_ready=0; drive 3 consecutive valid words P0,P1,P2 → only P0,P1 accepted, in_ready=0 after second push, P2 held.
   - Raise out_ready → outputs P0,P1,P2 in order, no duplicates, no drops.
6. Reset and clear:
   - Assert rst_n=0 with count=2 → out_valid=0, out_result=0, sticky_flags=0 immediately.
   - After release, flag_clr pulse with no push → sticky_flags=000.
   - flag_clr concurrent with an overflow push → sticky_flags=010.
